async_fifo_wr_ctrl: RTL and testbench
=====================================

Name: async_fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the dual-clock FIFO. It runs entirely in the write clock domain and brings the read-domain Gray pointer across through its own 2-flop synchronizer. It owns the binary and Gray write pointers, drives the RAM write enable and address, and produces the full, almost-full, fill-count and overflow indications. The read domain consumes o_wr_gptr through its own synchronizer.

Parameters:
ADDR_BIT, 4, RAM address width; FIFO depth = 2**ADDR_BIT; pointers are ADDR_BIT+1 bits.
AFULL_LVL, 12, o_afull asserts when fill count >= AFULL_LVL; legal range 1..2**ADDR_BIT.

Ports:
clk  in  1  write-domain clock
rst_n  in  1  asynchronous active-low reset
i_wr_req  in  1  push request, one word per cycle
i_rd_gptr  in  ADDR_BIT+1  read pointer (Gray), asynchronous to clk
o_wr_en  out  1  RAM write strobe (accepted push)
o_wr_addr  out  ADDR_BIT  RAM write address
o_wr_gptr  out  ADDR_BIT+1  registered write pointer (Gray), sent to read domain
o_full  out  1  FIFO full, registered
o_afull  out  1  almost full, registered
o_wr_cnt  out  ADDR_BIT+1  fill count seen from write side, registered, range 0..2**ADDR_BIT
o_ovf_err  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- One clock domain, clk. Reset is asynchronous on rst_n low and synchronously released by the integrator. Reset sets every register and output to 0: pointers, synchronizer stages, o_full, o_afull, o_wr_cnt, o_ovf_err.
- Synchronizer: i_rd_gptr passes through two flops, each reset to 0, giving rgptr_s. No logic sits between the two stages. rgptr_s is converted Gray->binary (rbin_s) for counting only.
- Accept: o_wr_en = i_wr_req & ~o_full. This is combinational, so the write takes effect in the same cycle.
- o_wr_addr = wbin[ADDR_BIT-1:0], taken directly from the register.
- Pointer update:
  - wbin_nxt = wbin + o_wr_en, modulo 2**(ADDR_BIT+1).
  - wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1).
  - wbin and o_wr_gptr both register on every clk edge, so o_wr_gptr changes at most one bit per cycle.
- Full:
  - Condition: o_full <= (wgray_nxt == {~rgptr_s[ADDR_BIT:ADDR_BIT-1], rgptr_s[ADDR_BIT-2:0]}).
  - Assertion occurs on the same edge that accepts the last free slot.
- Count and almost full:
  - o_wr_cnt <= wbin_nxt - rbin_s, modulo 2**(ADDR_BIT+1).
  - o_afull <= (wbin_nxt - rbin_s) >= AFULL_LVL.
- Flag timing: full, almost-full and count are pessimistic. A read-pointer advance stable before clk edge N is reflected in o_full, o_afull and o_wr_cnt after edge N+2, i.e. 3 edges of latency. A write is reflected on the next edge.
- Push while full: ignored. No pointer change, o_wr_en=0, RAM is not written.
- Simultaneous push and read advance while full: the push is still rejected because it is evaluated against the registered o_full. The flag clears per the latency above.
- Wrap-around: the pointer MSB toggles every 2**ADDR_BIT writes. Full/empty is distinguished only by the MSB/Gray compare; no extra state is kept.
- Reset mid-operation: all state clears immediately, regardless of in-flight pushes. The read domain must be reset in the same reset event.

Optional Feature:
Macro ASYNC_FIFO_OVF_CHK_EN.
- Defined: o_ovf_err is set on the clk edge following any cycle with i_wr_req=1 and o_full=1. It stays set until rst_n asserts.
- Undefined: o_ovf_err is tied to 0 and no check register is built. The port list is identical in both builds.

Test Plan:
1. Fill to full (ADDR_BIT=4, i_rd_gptr=0): push 16 times.
   - o_wr_addr steps 0..15.
   - o_afull rises after the 12th write, when o_wr_cnt=12.
   - o_full rises after the 16th write, with o_wr_cnt=16 and o_wr_gptr=5'b11000.
2. Overflow: from full, push 3 more.
   - o_wr_en stays 0 and o_wr_addr stays 0.
   - o_ovf_err=1 one cycle after the first rejected push (macro defined) or stays 0 (macro undefined).
3. Drain visibility: from full, set i_rd_gptr=5'b00110 (binary 4) before edge N.
   - o_full=0 and o_wr_cnt=12 after edge N+2.
   - o_afull stays 1 because 12>=12.
   - Set i_rd_gptr=Gray(5), i.e. binary 5: o_afull=0 three edges later.
4. Wrap: run 40 pushes with a model reader advancing i_rd_gptr in Gray.
   - o_wr_addr wraps 15->0.
   - o_wr_gptr changes only one bit per step.
   - No false full occurs while o_wr_cnt<16.
5. Simultaneous: at full, push and advance the read pointer in the same cycle.
   - The push is rejected.
   - The next push after o_full falls is accepted at the correct address.
6. Reset mid-operation: assert rst_n at o_wr_cnt=7, off-edge.
   - All outputs are 0 immediately, without waiting for a clk edge.
   - After release, the first push writes address 0.

Source files
------------

// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-side pointer/flag controller for a dual-clock FIFO.
// Runs in the write clock domain. The read-side Gray pointer comes in through a
// 2-flop synchronizer. Full, almost-full and count are pessimistic.
// Optional build macro: ASYNC_FIFO_OVF_CHK_EN (sticky overflow flag).
module async_fifo_wr_ctrl #(
  parameter int unsigned ADDR_BIT  = 4,
  parameter int unsigned AFULL_LVL = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_req,
  input  logic [ADDR_BIT:0]   i_rd_gptr,
  output logic                o_wr_en,
  output logic [ADDR_BIT-1:0] o_wr_addr,
  output logic [ADDR_BIT:0]   o_wr_gptr,
  output logic                o_full,
  output logic                o_afull,
  output logic [ADDR_BIT:0]   o_wr_cnt,
  output logic                o_ovf_err
);

  localparam int unsigned   PW        = ADDR_BIT + 1;
  localparam logic [PW-1:0] AFULL_V   = PW'(AFULL_LVL);
  // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] rgptr_s1_q;
  logic [PW-1:0] rgptr_s2_q;
  logic [PW-1:0] rbin_s;

  logic [PW-1:0] wbin_q,  wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          full_q,  full_d;
  logic          afull_q, afull_d;
  logic [PW-1:0] cnt_q,   cnt_d;
  logic          wr_en;

  // Two-stage synchronizer for the read-domain Gray pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgptr_s1_q <= '0;
      rgptr_s2_q <= '0;
    end else begin
      rgptr_s1_q <= i_rd_gptr;
      rgptr_s2_q <= rgptr_s1_q;
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_s = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin_s[i] = ^(rgptr_s2_q >> i);
    end
  end

  // Accept logic, next pointers and next flags.
  always_comb begin
    wr_en   = i_wr_req & ~full_q;
    wbin_d  = wbin_q + PW'(wr_en);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    cnt_d   = wbin_d - rbin_s;
    full_d  = (wgray_d == (rgptr_s2_q ^ FULL_MASK));
    afull_d = (cnt_d >= AFULL_V);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ASYNC_FIFO_OVF_CHK_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: any push attempted while full.
  always_comb begin
    ovf_d = ovf_q | (i_wr_req & full_q);
  end

  // Overflow flag register, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign o_ovf_err = ovf_q;
`else
  assign o_ovf_err = 1'b0;
`endif

  assign o_wr_en   = wr_en;
  assign o_wr_addr = wbin_q[ADDR_BIT-1:0];
  assign o_wr_gptr = wgray_q;
  assign o_full    = full_q;
  assign o_afull   = afull_q;
  assign o_wr_cnt  = cnt_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Testbench for async_fifo_wr_ctrl (ADDR_BIT=4, AFULL_LVL=12).
// Honours ASYNC_FIFO_OVF_CHK_EN the same way as the design.
module tb_async_fifo_wr_ctrl;

  logic       clk;
  logic       rst_n;
  logic       i_wr_req;
  logic [4:0] i_rd_gptr;
  logic       o_wr_en;
  logic [3:0] o_wr_addr;
  logic [4:0] o_wr_gptr;
  logic       o_full;
  logic       o_afull;
  logic [4:0] o_wr_cnt;
  logic       o_ovf_err;

  int checks   = 0;
  int failures = 0;

`ifdef ASYNC_FIFO_OVF_CHK_EN
  localparam int OVF_EXP = 1;
`else
  localparam int OVF_EXP = 0;
`endif

  async_fifo_wr_ctrl #(.ADDR_BIT(4), .AFULL_LVL(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_req  (i_wr_req),
    .i_rd_gptr (i_rd_gptr),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_wr_gptr (o_wr_gptr),
    .o_full    (o_full),
    .o_afull   (o_afull),
    .o_wr_cnt  (o_wr_cnt),
    .o_ovf_err (o_ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  int rd_bin;
  always_comb i_rd_gptr = gray5(rd_bin);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: writes counted as an integer, reader position seen two edges late.
  int m_wr, m_cnt, m_d1, m_d2;
  int m_full, m_afull, m_ovf;
  int m_acc, m_wr_next, m_cnt_next;

  always_comb begin
    m_acc      = (i_wr_req === 1'b1 && m_full == 0) ? 1 : 0;
    m_wr_next  = (m_wr + m_acc) % 32;
    m_cnt_next = (m_wr_next - m_d2) & 31;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr <= 0; m_cnt <= 0; m_d1 <= 0; m_d2 <= 0;
      m_full <= 0; m_afull <= 0; m_ovf <= 0;
    end else begin
      m_wr    <= m_wr_next;
      m_cnt   <= m_cnt_next;
      m_full  <= (m_cnt_next == 16) ? 1 : 0;
      m_afull <= (m_cnt_next >= 12) ? 1 : 0;
      m_d1    <= rd_bin & 31;
      m_d2    <= m_d1;
`ifdef ASYNC_FIFO_OVF_CHK_EN
      if (i_wr_req === 1'b1 && m_full == 1) m_ovf <= 1;
`endif
    end
  end

  // Per-cycle compare against the model, plus Gray single-step and wrap tracking.
  int prev_valid = 0;
  int prev_g     = 0;
  int prev_addr  = 0;
  int saw_wrap   = 0;

  always @(negedge clk) begin
    chk("wr_en",  int'(o_wr_en),   m_acc);
    chk("addr",   int'(o_wr_addr), m_wr % 16);
    chk("gptr",   int'(o_wr_gptr), int'(gray5(m_wr)));
    chk("full",   int'(o_full),    m_full);
    chk("afull",  int'(o_afull),   m_afull);
    chk("cnt",    int'(o_wr_cnt),  m_cnt);
    chk("ovf",    int'(o_ovf_err), m_ovf);
    if (rst_n) begin
      if (prev_valid != 0) begin
        chk("gptr_step", ($countones(o_wr_gptr ^ prev_g[4:0]) <= 1) ? 1 : 0, 1);
        if (prev_addr == 15 && o_wr_addr == 4'd0) saw_wrap = 1;
      end
      prev_valid = 1;
      prev_g     = int'(o_wr_gptr);
      prev_addr  = int'(o_wr_addr);
    end else begin
      prev_valid = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, int'(o_wr_en),   0);
    chk({tag, "_addr"},  int'(o_wr_addr), 0);
    chk({tag, "_gptr"},  int'(o_wr_gptr), 0);
    chk({tag, "_full"},  int'(o_full),    0);
    chk({tag, "_afull"}, int'(o_afull),   0);
    chk({tag, "_cnt"},   int'(o_wr_cnt),  0);
    chk({tag, "_ovf"},   int'(o_ovf_err), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    i_wr_req = 1'b0;
    rd_bin   = 0;
    #12;
    chk_all_zero("reset");
    tick();
    rst_n = 1'b1;

    // Fill 16 words with the reader parked at 0.
    for (int i = 0; i < 16; i++) begin
      i_wr_req = 1'b1;
      #1;
      chk("fill_addr", int'(o_wr_addr), i);
      chk("fill_en",   int'(o_wr_en),   1);
      tick();
      if (i == 10) chk("afull_at11", int'(o_afull), 0);
      if (i == 11) begin
        chk("afull_at12", int'(o_afull),  1);
        chk("cnt_at12",   int'(o_wr_cnt), 12);
      end
      if (i == 14) chk("full_at15", int'(o_full), 0);
    end
    i_wr_req = 1'b0;
    chk("full_at16", int'(o_full),    1);
    chk("cnt_at16",  int'(o_wr_cnt),  16);
    chk("gptr_16",   int'(o_wr_gptr), 24);

    // Overflow: three pushes while full are all rejected.
    for (int i = 0; i < 3; i++) begin
      i_wr_req = 1'b1;
      #1;
      chk("ovf_en",   int'(o_wr_en),   0);
      chk("ovf_addr", int'(o_wr_addr), 0);
      tick();
      if (i == 0) chk("ovf_flag", int'(o_ovf_err), OVF_EXP);
    end
    i_wr_req = 1'b0;
    chk("ovf_cnt", int'(o_wr_cnt), 16);

    // Drain visibility: reader to 4, seen after the third edge.
    rd_bin = 4;
    tick();
    tick();
    chk("drain_full_n1", int'(o_full), 1);
    tick();
    chk("drain_full_n2",  int'(o_full),   0);
    chk("drain_cnt_n2",   int'(o_wr_cnt), 12);
    chk("drain_afull_n2", int'(o_afull),  1);
    rd_bin = 5;
    tick();
    tick();
    chk("afull_hold", int'(o_afull), 1);
    tick();
    chk("afull_drop", int'(o_afull),  0);
    chk("cnt_11",     int'(o_wr_cnt), 11);

    // Refill, then push and advance the reader in the same cycle.
    i_wr_req = 1'b1;
    repeat (5) tick();
    i_wr_req = 1'b0;
    chk("refull",     int'(o_full),   1);
    chk("refull_cnt", int'(o_wr_cnt), 16);
    i_wr_req = 1'b1;
    rd_bin   = 6;
    #1;
    chk("sim_rej0", int'(o_wr_en), 0);
    tick();
    chk("sim_rej1", int'(o_wr_en), 0);
    tick();
    chk("sim_rej2", int'(o_wr_en), 0);
    tick();
    chk("sim_full_clr", int'(o_full),    0);
    chk("sim_acc_en",   int'(o_wr_en),   1);
    chk("sim_acc_addr", int'(o_wr_addr), 5);
    tick();
    chk("sim_next_addr", int'(o_wr_addr), 6);
    chk("sim_full_again", int'(o_full),   1);
    i_wr_req = 1'b0;

    // Wrap: 40 pushes with a reader trailing the writer.
    saw_wrap = 0;
    for (int i = 0; i < 40; i++) begin
      i_wr_req = 1'b1;
      if (((m_wr - rd_bin) & 31) > 3) rd_bin = (rd_bin + 1) & 31;
      tick();
    end
    i_wr_req = 1'b0;
    chk("wrap_seen", saw_wrap, 1);

    // Catch reader up, push 7, then reset off-edge.
    rd_bin = m_wr;
    repeat (4) tick();
    chk("empty_cnt",  int'(o_wr_cnt), 0);
    chk("empty_full", int'(o_full),   0);
    i_wr_req = 1'b1;
    repeat (7) tick();
    i_wr_req = 1'b0;
    chk("cnt_7", int'(o_wr_cnt), 7);
    #2;
    rst_n  = 1'b0;
    rd_bin = 0;
    #1;
    chk_all_zero("midreset");
    tick();
    tick();
    rst_n    = 1'b1;
    i_wr_req = 1'b1;
    #1;
    chk("post_rst_en",   int'(o_wr_en),   1);
    chk("post_rst_addr", int'(o_wr_addr), 0);
    tick();
    i_wr_req = 1'b0;
    chk("post_rst_addr1", int'(o_wr_addr), 1);
    chk("post_rst_cnt1",  int'(o_wr_cnt),  1);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
